// File: rtl/complex_mult.sv
// complex_mult: three-stage pipelined signed complex multiplier.
//   (dina_i + j*dina_q) * (dinb_i + j*dinb_q), full precision, no rounding.
//   Stage 1 registers the operands, stage 2 the partial products, and
//   stage 3 the final I/Q sums. Latency is 3 clocks and one result is
//   produced per clock.
// Build option: define COMPLEX_MULT_GAUSS_EN to use the 3-multiplier Gauss
//   form in stage 2. Ports, latency and results are identical in both builds.
module complex_mult #(
  parameter  int DINA_WIDTH = 8,
  parameter  int DINB_WIDTH = 8,
  localparam int MULT_WIDTH = DINA_WIDTH + DINB_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din_valid,
  input  logic signed [DINA_WIDTH-1:0] dina_i,
  input  logic signed [DINA_WIDTH-1:0] dina_q,
  input  logic signed [DINB_WIDTH-1:0] dinb_i,
  input  logic signed [DINB_WIDTH-1:0] dinb_q,
  output logic                         dout_valid,
  output logic signed [MULT_WIDTH-1:0] mult_i,
  output logic signed [MULT_WIDTH-1:0] mult_q
);

  // Full-precision width of a single A*B product.
  localparam int PW = DINA_WIDTH + DINB_WIDTH;

  // Sign-extend a product to the output width ahead of add/sub.
  function automatic logic signed [MULT_WIDTH-1:0] sext_prod(input logic signed [PW-1:0] p);
    return MULT_WIDTH'(p);
  endfunction

  // Stage 1 registers
  logic                         r_vld_p0;
  logic signed [DINA_WIDTH-1:0] r_ai_p0;
  logic signed [DINA_WIDTH-1:0] r_aq_p0;
  logic signed [DINB_WIDTH-1:0] r_bi_p0;
  logic signed [DINB_WIDTH-1:0] r_bq_p0;

  // Stage 3 registers
  logic                         r_vld_p2;
  logic signed [MULT_WIDTH-1:0] r_mi_p2;
  logic signed [MULT_WIDTH-1:0] r_mq_p2;

  // ---- Stage 1: capture valid and operands every cycle ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_ai_p0  <= '0;
      r_aq_p0  <= '0;
      r_bi_p0  <= '0;
      r_bq_p0  <= '0;
    end else begin
      r_vld_p0 <= din_valid;
      r_ai_p0  <= dina_i;
      r_aq_p0  <= dina_q;
      r_bi_p0  <= dinb_i;
      r_bq_p0  <= dinb_q;
    end
  end

`ifdef COMPLEX_MULT_GAUSS_EN
  // Pre-adders are one bit wider than their operands so they cannot wrap.
  localparam int AW1 = DINA_WIDTH + 1;
  localparam int BW1 = DINB_WIDTH + 1;

  // Products of a (W+1)-bit pre-sum and the other operand need MULT_WIDTH bits.
  function automatic logic signed [MULT_WIDTH-1:0] ext_k(input logic signed [MULT_WIDTH-1:0] v);
    return v;
  endfunction

  logic                         r_vld_p1;
  logic signed [MULT_WIDTH-1:0] r_k1_p1;
  logic signed [MULT_WIDTH-1:0] r_k2_p1;
  logic signed [MULT_WIDTH-1:0] r_k3_p1;

  logic signed [AW1-1:0]        w_sum_a;
  logic signed [BW1-1:0]        w_dif_b;
  logic signed [BW1-1:0]        w_sum_b;

  // Gauss pre-adders: a_i+a_q, b_q-b_i, b_i+b_q.
  always_comb begin
    w_sum_a = AW1'(r_ai_p0) + AW1'(r_aq_p0);
    w_dif_b = BW1'(r_bq_p0) - BW1'(r_bi_p0);
    w_sum_b = BW1'(r_bi_p0) + BW1'(r_bq_p0);
  end

  // ---- Stage 2: three Gauss products k1, k2, k3 ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_k1_p1  <= '0;
      r_k2_p1  <= '0;
      r_k3_p1  <= '0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      r_k1_p1  <= ext_k(MULT_WIDTH'(r_bi_p0)) * ext_k(MULT_WIDTH'(w_sum_a));
      r_k2_p1  <= ext_k(MULT_WIDTH'(r_ai_p0)) * ext_k(MULT_WIDTH'(w_dif_b));
      r_k3_p1  <= ext_k(MULT_WIDTH'(r_aq_p0)) * ext_k(MULT_WIDTH'(w_sum_b));
    end
  end

  // ---- Stage 3: I = k1 - k3, Q = k1 + k2 ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p2 <= 1'b0;
      r_mi_p2  <= '0;
      r_mq_p2  <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      r_mi_p2  <= r_k1_p1 - r_k3_p1;
      r_mq_p2  <= r_k1_p1 + r_k2_p1;
    end
  end
`else
  // Operands are widened to the product width so the multiply is exact.
  function automatic logic signed [PW-1:0] ext_a(input logic signed [DINA_WIDTH-1:0] v);
    return PW'(v);
  endfunction

  function automatic logic signed [PW-1:0] ext_b(input logic signed [DINB_WIDTH-1:0] v);
    return PW'(v);
  endfunction

  logic                 r_vld_p1;
  logic signed [PW-1:0] r_ii_p1;
  logic signed [PW-1:0] r_qq_p1;
  logic signed [PW-1:0] r_iq_p1;
  logic signed [PW-1:0] r_qi_p1;

  // ---- Stage 2: four full-precision partial products ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_ii_p1  <= '0;
      r_qq_p1  <= '0;
      r_iq_p1  <= '0;
      r_qi_p1  <= '0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      r_ii_p1  <= ext_a(r_ai_p0) * ext_b(r_bi_p0);
      r_qq_p1  <= ext_a(r_aq_p0) * ext_b(r_bq_p0);
      r_iq_p1  <= ext_a(r_ai_p0) * ext_b(r_bq_p0);
      r_qi_p1  <= ext_a(r_aq_p0) * ext_b(r_bi_p0);
    end
  end

  // ---- Stage 3: I = ii - qq, Q = iq + qi ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p2 <= 1'b0;
      r_mi_p2  <= '0;
      r_mq_p2  <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      r_mi_p2  <= sext_prod(r_ii_p1) - sext_prod(r_qq_p1);
      r_mq_p2  <= sext_prod(r_iq_p1) + sext_prod(r_qi_p1);
    end
  end
`endif

  assign dout_valid = r_vld_p2;
  assign mult_i     = r_mi_p2;
  assign mult_q     = r_mq_p2;

endmodule

// File: tb/tb_complex_mult.sv
// Testbench for complex_mult: a scoreboard queue of expected results with
// due cycles, filled by the stimulus and drained by a monitor process.
module tb_complex_mult;

  localparam int AW = 8;
  localparam int BW = 8;
  localparam int MW = AW + BW + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 din_valid = 1'b0;
  logic signed [AW-1:0] dina_i = '0;
  logic signed [AW-1:0] dina_q = '0;
  logic signed [BW-1:0] dinb_i = '0;
  logic signed [BW-1:0] dinb_q = '0;
  logic                 dout_valid;
  logic signed [MW-1:0] mult_i;
  logic signed [MW-1:0] mult_q;

  complex_mult #(.DINA_WIDTH(AW), .DINB_WIDTH(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .dina_i     (dina_i),
    .dina_q     (dina_q),
    .dinb_i     (dinb_i),
    .dinb_q     (dinb_q),
    .dout_valid (dout_valid),
    .mult_i     (mult_i),
    .mult_q     (mult_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint ei;
    longint eq;
    int     due;
  } exp_t;

  exp_t q_exp[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one sample on the falling edge; it is sampled at the next rising
  // edge and must be visible at the falling edge 3 cycles after this one.
  task automatic drive(input logic v, input int ai, input int aq, input int bi, input int bq,
                       input longint ei, input longint eq);
    exp_t e;
    @(negedge clk);
    din_valid = v;
    dina_i = AW'(ai);
    dina_q = AW'(aq);
    dinb_i = BW'(bi);
    dinb_q = BW'(bq);
    if (v) begin
      e.ei = ei;
      e.eq = eq;
      e.due = cyc + 3;
      q_exp.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every valid output against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (q_exp.size() > 0 && q_exp[0].due < cyc) begin
          e = q_exp.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_output: dout_valid absent, expected (%0d,%0d) at cycle %0d", e.ei, e.eq, e.due);
        end
        if (dout_valid) begin
          if (q_exp.size() == 0 || q_exp[0].due != cyc) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: dout_valid=1 with (%0d,%0d) at cycle %0d, none expected", mult_i, mult_q, cyc);
          end else begin
            e = q_exp.pop_front();
            check("mult_i", longint'(mult_i), e.ei);
            check("mult_q", longint'(mult_q), e.eq);
          end
        end
      end
    end
  end

  initial begin
    int ai, aq, bi, bq;
    logic v;
    int wait_n;

    // Reset state
    #1;
    check("rst_valid", longint'(dout_valid), 0);
    check("rst_i", longint'(mult_i), 0);
    check("rst_q", longint'(mult_q), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      check("hold_valid", longint'(dout_valid), 0);
      check("hold_i", longint'(mult_i), 0);
      check("hold_q", longint'(mult_q), 0);
    end

    // Basic single pulse
    drive(1'b1, 4, 5, 5, 4, 0, 41);
    idle(4);

    // Back-to-back sweep: a=(i,j), b=(j,i) -> (0, i^2+j^2)
    for (int i = 4; i <= 15; i++)
      for (int j = 4; j <= 15; j++)
        drive(1'b1, i, j, j, i, 0, longint'(i * i + j * j));

    // Extremes
    drive(1'b1, -128, -128, -128, -128, 0, 32768);
    drive(1'b1, -128, 127, -128, -128, 32640, 128);
    drive(1'b1, -128, -128, 127, -128, -32640, 128);
    idle(1);

    // Asynchronous reset with nonzero pipeline contents, no clock edge
    #3;
    check("pre_async_i", longint'(mult_i), 0);
    rst = 1'b1;
    q_exp.delete();
    #1;
    check("async_valid", longint'(dout_valid), 0);
    check("async_i", longint'(mult_i), 0);
    check("async_q", longint'(mult_q), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      check("post_rst_valid", longint'(dout_valid), 0);
      check("post_rst_i", longint'(mult_i), 0);
      check("post_rst_q", longint'(mult_q), 0);
    end

    // Mid-stream reset after the 2nd of 5 samples
    drive(1'b1, 1, 1, 1, 1, 0, 2);
    drive(1'b1, 2, 3, 4, 5, -7, 22);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q_exp.delete();
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 3, -2, 7, 1, 23, -11);
    drive(1'b1, -10, 6, -3, -9, 84, 72);
    drive(1'b1, 100, -50, 20, 30, 3500, 2000);
    idle(4);

    // Random operands with random valid
    for (int k = 0; k < 2000; k++) begin
      v  = 1'($urandom_range(0, 1));
      ai = int'($urandom_range(0, 255)) - 128;
      aq = int'($urandom_range(0, 255)) - 128;
      bi = int'($urandom_range(0, 255)) - 128;
      bq = int'($urandom_range(0, 255)) - 128;
      drive(v, ai, aq, bi, bq,
            longint'(ai) * longint'(bi) - longint'(aq) * longint'(bq),
            longint'(ai) * longint'(bq) + longint'(aq) * longint'(bi));
    end

    // Drain, bounded
    wait_n = 0;
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    while (q_exp.size() > 0 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    if (q_exp.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q_exp.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
